// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: FSM state encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;
    assign cnt      = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: full-throughput valid/ready stage whose in_ready is
// registered-only (no combinational path from out_ready), plus a stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;
    logic             w_stall;

    assign in_ready  = (r_state != TWO) && !rst;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    assign w_stall   = out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush wins over everything; an input accepted in the same cycle is dropped.
    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_hs) begin
                        w_load_main  = 1'b1;
                        w_state_next = ONE;
                    end
                end
                ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        w_load_main = 1'b1;
                    end else if (w_in_hs) begin
                        w_load_skid  = 1'b1;
                        w_state_next = TWO;
                    end else if (w_out_hs) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_out_hs) begin
                        w_main_from_skid = 1'b1;
                        w_state_next     = ONE;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(w_stall),
        .clr(cnt_clr),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg with a FIFO scoreboard of accepted payloads.
module tb_pipe_skid_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] sb_q[$];

    pipe_skid_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes mid-cycle, update the scoreboard, then advance one edge.
    task automatic cycle();
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_d = sb_q.pop_front();
                chk("sb_out_data", 32'(out_data), 32'(exp_d));
                $display("OUT  data=%02h", out_data);
            end
        end
        if (flush) begin
            sb_q.delete();
            $display("FLUSH");
        end else if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
            $display("IN   data=%02h", in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11; cycle();
        chk("stream_latency_valid", 32'(out_valid), 32'd1);
        chk("stream_latency_data", 32'(out_data), 32'h11);
        in_data   = 8'h22; cycle();
        chk("stream_data2", 32'(out_data), 32'h22);
        in_data   = 8'h33; cycle();
        chk("stream_data3", 32'(out_data), 32'h33);
        in_valid  = 1'b0; cycle();
        cycle();
        chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1; cycle();
        chk("bp_ready_after_first", 32'(in_ready), 32'd1);
        in_data   = 8'hA2; cycle();
        chk("bp_ready_after_second", 32'(in_ready), 32'd0);
        chk("bp_stall_1", 32'(stall_cnt), 32'd1);
        in_valid  = 1'b0; cycle(); cycle();
        chk("bp_stall_3", 32'(stall_cnt), 32'd3);
        chk("bp_head_data", 32'(out_data), 32'hA1);
        out_ready = 1'b1; cycle();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_second_data", 32'(out_data), 32'hA2);
        cycle();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_stall_hold", 32'(stall_cnt), 32'd3);

        // Flush while full, with a concurrent input
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        chk("clr_stall", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB1; cycle();
        in_data   = 8'hB2; cycle();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush     = 1'b1;
        in_data   = 8'hB3; cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_stall_kept", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1; cycle(); cycle();
        chk("fl_no_b3", 32'(out_valid), 32'd0);

        // Saturation of the stall counter
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hD1; cycle();
        in_valid  = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_hold_15", 32'(stall_cnt), 32'd15);
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        chk("sat_clr_wins", 32'(stall_cnt), 32'd0);
        cycle();
        chk("sat_restart", 32'(stall_cnt), 32'd1);
        out_ready = 1'b1; cycle();
        chk("sat_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC5; cycle();
        in_valid  = 1'b0;
        chk("ar_holding", 32'(out_data), 32'hC5);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_data", 32'(out_data), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
        sb_q.delete();
        $display("RESET async");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ar_release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1; cycle(); cycle();
        chk("ar_no_emit", 32'(out_valid), 32'd0);
        chk("sb_final_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..256.
REQ-002 Parameter CNT_W, default 16: stall-counter width in bits; legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  downstream payload valid.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-013 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-014 The block SHALL hold up to two entries: main (drives out_data) and skid.
REQ-015 The state machine SHALL have three states: EMPTY (no entries), ONE (main full), TWO (main and skid full).
REQ-016 in_ready SHALL be 1 when the state is not TWO and rst is low; it SHALL depend only on state and rst, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO; out_data SHALL equal main.
REQ-018 An input handshake occurs when in_valid and in_ready are both 1; an output handshake occurs when out_valid and out_ready are both 1.
REQ-019 From EMPTY with an input handshake: main <= in_data, next state ONE; latency from input to out_valid is 1 cycle.
REQ-020 From ONE with input and output handshakes: main <= in_data, stay in ONE (full throughput, 1 payload/cycle).
REQ-021 From ONE with an input handshake and no output handshake: skid <= in_data, next state TWO.
REQ-022 From ONE with an output handshake and no input handshake: next state EMPTY.
REQ-023 From TWO with an output handshake: main <= skid, next state ONE. Input is not accepted in TWO.
REQ-024 Without any handshake, state and entries SHALL be unchanged; payload order SHALL be strictly FIFO.
REQ-025 flush SHALL take priority over all transitions: next state EMPTY, and any input handshake in the same cycle is discarded.
REQ-026 An output handshake in a flush cycle SHALL count as delivered.
REQ-027 Entry data registers need not be cleared on flush.
REQ-028 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 with no wrap.
REQ-029 cnt_clr SHALL set stall_cnt to 0 and take priority over an increment in the same cycle.
REQ-030 flush SHALL NOT affect stall_cnt.

Reset
REQ-031 When rst is asserted, the state SHALL become EMPTY immediately, without waiting for a clock edge.
REQ-032 When rst is asserted, main, skid and stall_cnt SHALL become 0; out_valid=0, in_ready=0 and out_data=0 SHALL hold while rst is high.
REQ-033 Reset asserted mid-operation SHALL drop all held payloads without emitting them.
REQ-034 in_ready SHALL become 1 in the first cycle after rst deasserts.

Structure
REQ-035 A shared package pipe_pkg SHALL hold the state enum typedef (EMPTY, ONE, TWO) and its 2-bit encoding.
REQ-036 The saturating stall counter SHALL be a separate sub-module sat_counter, parametrised by CNT_W, with inc and clr inputs.
REQ-037 The FSM, main register and skid register SHALL reside in pipe_skid_reg.

Verification
REQ-038 Streaming: out_ready=1, payloads 0x11,0x22,0x33 on consecutive cycles -> the same values appear on out_data on consecutive cycles, 1 cycle later; stall_cnt=0.
REQ-039 Back-pressure: send 0xA1,0xA2 with out_ready=0 -> in_ready=0 after the second accept; stall_cnt counts each stalled cycle; out_ready=1 -> 0xA1 then 0xA2 in order; in_ready returns to 1.
REQ-040 Flush in TWO holding 0xB1,0xB2, with in_valid=1 data 0xB3 -> next cycle out_valid=0, in_ready=1; 0xB3 never appears.
REQ-041 Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt holds 15; cnt_clr together with a stall -> 0.
REQ-042 Async reset: assert rst between clock edges in state ONE holding 0xC5 -> out_valid=0 and out_data=0 at once; in_ready=1 in the first cycle after release.
